// File: rtl/doc_uart_pkg.sv
// Shared state encoding and baud helpers for the document UART sender.
package doc_uart_pkg;

    // One encoding for both FSMs.
    // The serializer walks IDLE/START/DATA/STOP.
    // The top walks IDLE/FETCH/SEND/TERM/DONE, where SEND means a byte is on the line.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_TERM,
        ST_DONE,
        ST_SEND
    } state_t;

    // Clocks per bit, truncated.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // One FETCH cycle plus start, eight data bits and stop.
    function automatic int byte_cycles(input int div);
        return 1 + 10 * div;
    endfunction

    localparam int DEFAULT_DIV = baud_div(25000000, 115200);
    localparam int BYTE_CYCLES = byte_cycles(DEFAULT_DIV);

endpackage

// File: rtl/doc_uart_sender_uart_tx_byte.sv
// Single-byte 8N1 serializer.
// start/data are taken while ready is high.
// frame_end flags the last cycle of the stop bit.
module uart_tx_byte
    import doc_uart_pkg::*;
#(
    parameter int DIV = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       frame_end,
    output logic       tx
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [2:0]       bit_reg,    bit_next;
    logic [7:0]       shift_reg,  shift_next;
    logic             tx_reg,     tx_next;
    logic             baud_tick;

    assign baud_tick = (cnt_reg == CNT_LAST);
    assign ready     = (state_reg == ST_IDLE);
    assign frame_end = (state_reg == ST_STOP) && baud_tick;
    assign tx        = tx_reg;

    // Register the serializer state; the line idles high after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // Next-state logic.
    // tx is registered, so each level is set on the edge that enters its bit period.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (start) begin
                    shift_next = data;
                    cnt_next   = '0;
                    bit_next   = '0;
                    tx_next    = 1'b0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    cnt_next   = '0;
                    tx_next    = shift_reg[0];
                    state_next = ST_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = ST_STOP;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/doc_uart_sender.sv
// Streams every document cell, plus an optional terminator, out as UART 8N1.
// Pulses done afterwards so the editor clears the document.
module doc_uart_sender
    import doc_uart_pkg::*;
#(
    parameter int         CLK_HZ    = 25000000,
    parameter int         BAUD      = 115200,
    parameter int         ADDR_W    = 10,
    parameter int         DOC_DEPTH = 512,
    parameter bit         TERM_EN   = 1'b1,
    parameter logic [7:0] TERM_BYTE = 8'h0A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int                DIV       = baud_div(CLK_HZ, BAUD);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DOC_DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg,  addr_next;
    logic              term_reg,  term_next;   // current byte is the terminator
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              tx_frame_end;

    assign rd_addr = addr_reg;
    assign rd_en   = (state_reg != ST_IDLE);
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);

    uart_tx_byte #(
        .DIV (DIV)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (tx_start),
        .data      (tx_data),
        .ready     (tx_ready),
        .frame_end (tx_frame_end),
        .tx        (tx)
    );

    // Register the sequencing state and the read address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            term_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            term_reg  <= term_next;
        end
    end

    // Cell walk. rd_data is sampled only in FETCH.
    // A send arriving while busy is ignored.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        term_next  = term_reg;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        case (state_reg)
            ST_IDLE: begin
                if (send) begin
                    addr_next  = '0;
                    term_next  = 1'b0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                tx_start   = tx_ready;
                tx_data    = term_reg ? TERM_BYTE : rd_data;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (tx_frame_end) begin
                    if (!term_reg && (addr_reg != LAST_ADDR)) begin
                        addr_next  = addr_reg + ADDR_W'(1);
                        state_next = ST_FETCH;
                    end else if (!term_reg && TERM_EN) begin
                        state_next = ST_TERM;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_TERM: begin
                term_next  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_DONE: begin
                addr_next  = '0;
                term_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                addr_next  = '0;
                term_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
